// File: rtl/hilo_ctrl_pkg.sv
// Shared constants and types for the multiply / HI-LO control stage.
package hilo_ctrl_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned PROD_W      = 2 * DATA_W;
  localparam int unsigned MAX_LAT_DEF = 40;
  localparam int unsigned CNT_W_DEF   = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ARM   = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  // Product image as it lands in the architectural pair
  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;

endpackage

// File: rtl/hilo_ctrl_if.sv
// EX-side and multserial-side signals of the HI/LO control stage.
interface hilo_ctrl_if;
  import hilo_ctrl_pkg::*;

  logic              MULTE;
  logic              MSGNE;
  logic [DATA_W-1:0] RSE;
  logic [DATA_W-1:0] RTE;
  logic              MTHIE;
  logic              MTLOE;
  logic              MFHIE;
  logic              MFLOE;
  logic              MST;
  logic              MSGN;
  logic [DATA_W-1:0] SRCA;
  logic [DATA_W-1:0] SRCB;
  logic [PROD_W-1:0] PROD;
  logic              PRODV;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;
  logic              STALLMD;
  logic              ERR;

  modport master (
    output MULTE, MSGNE, RSE, RTE, MTHIE, MTLOE, MFHIE, MFLOE, PROD, PRODV,
    input  MST, MSGN, SRCA, SRCB, HI, LO, STALLMD, ERR
  );

  modport slave (
    input  MULTE, MSGNE, RSE, RTE, MTHIE, MTLOE, MFHIE, MFLOE, PROD, PRODV,
    output MST, MSGN, SRCA, SRCB, HI, LO, STALLMD, ERR
  );
endinterface

// File: rtl/hilo_ctrl.sv
// Multiply/HI-LO control: launches multserial, owns HI/LO, stalls EX while a
// multiply is outstanding and flags a sticky timeout.
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int unsigned MAX_LAT = MAX_LAT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  hilo_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] srca_q, srca_d;
  logic [DATA_W-1:0] srcb_q, srcb_d;
  logic              msgn_q, msgn_d;
  logic              mst_q, mst_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_c;
  hilo_t             prod_c;

  assign prod_c = hilo_t'(bus.PROD);
  // Final ARM/WAIT cycle before the counter reaches MAX_LAT
  assign last_c = (cnt_q == CNT_W'(MAX_LAT - 1));

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    srca_d  = srca_q;
    srcb_d  = srcb_q;
    msgn_d  = msgn_q;
    mst_d   = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.MULTE) begin
          srca_d  = bus.RSE;
          srcb_d  = bus.RTE;
          msgn_d  = bus.MSGNE;
          mst_d   = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          if (bus.MTHIE) hi_d = bus.RSE;
          if (bus.MTLOE) lo_d = bus.RSE;
        end
      end

      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_ARM;
      end

      // PRODV is still high from the previous product until multserial restarts
      ST_ARM: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (last_c) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (!bus.PRODV) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.PRODV) begin
          hi_d    = prod_c.hi;
          lo_d    = prod_c.lo;
          state_d = ST_IDLE;
        end else if (last_c) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      srca_q  <= '0;
      srcb_q  <= '0;
      msgn_q  <= 1'b0;
      mst_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
      msgn_q  <= msgn_d;
      mst_q   <= mst_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.MST     = mst_q;
  assign bus.MSGN    = msgn_q;
  assign bus.SRCA    = srca_q;
  assign bus.SRCB    = srcb_q;
  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;
  assign bus.ERR     = err_q;
  // Only HI/LO-touching instructions wait; independent code overlaps the multiply
  assign bus.STALLMD = (state_q != ST_IDLE) &
                       (bus.MULTE | bus.MTHIE | bus.MTLOE | bus.MFHIE | bus.MFLOE);

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl with a small behavioural multserial stand-in.
module tb_hilo_ctrl;

  localparam int unsigned MAX_LAT = 40;
  localparam int unsigned CNT_W   = 6;
  localparam int          M_LAT   = 4;

  logic clk;
  logic rst;
  bit   hold;
  int   m_cnt;
  int   n_cmp;
  int   n_bad;

  hilo_ctrl_if bus ();

  hilo_ctrl #(.MAX_LAT(MAX_LAT), .CNT_W(CNT_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mul(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (s) return {{32{a[31]}}, a} * {{32{b[31]}}, b};
    else   return {32'b0, a} * {32'b0, b};
  endfunction

  // multserial stand-in: PRODV falls after MST, rises M_LAT cycles later
  always @(posedge clk) begin
    if (rst) begin
      m_cnt     <= 0;
      bus.PRODV <= 1'b1;
      bus.PROD  <= '0;
    end else if (bus.MST) begin
      m_cnt     <= M_LAT;
      bus.PRODV <= 1'b0;
    end else if (m_cnt == 1 && !hold) begin
      bus.PROD  <= mul(bus.MSGN, bus.SRCA, bus.SRCB);
      bus.PRODV <= 1'b1;
      m_cnt     <= 0;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          mthi, mtlo, mfhi, mflo;
    logic [31:0] rse, exp_hi, exp_lo;
  } idle_vec_t;

  typedef struct {
    bit          sgn;
    logic [31:0] a, b;
    bit          mthi;
    logic [31:0] exp_hi, exp_lo;
  } mul_vec_t;

  task automatic do_mult(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input bit mthi, input logic [31:0] eh, input logic [31:0] el,
                         input bit eerr);
    int k;
    int mst_n;
    logic [31:0] hi_before;
    hi_before = bus.HI;
    @(negedge clk);
    bus.MULTE = 1'b1; bus.MSGNE = sgn; bus.RSE = a; bus.RTE = b; bus.MTHIE = mthi;
    @(negedge clk);
    bus.MULTE = 1'b0; bus.MTHIE = 1'b0; bus.MFLOE = 1'b1;
    chk("mst_issue", 64'(bus.MST), 64'd1);
    chk("srca", 64'(bus.SRCA), 64'(a));
    chk("srcb", 64'(bus.SRCB), 64'(b));
    chk("msgn", 64'(bus.MSGN), 64'(sgn));
    chk("hi_no_mthi", 64'(bus.HI), 64'(hi_before));
    mst_n = 1;
    #1 chk("stall_busy", 64'(bus.STALLMD), 64'd1);
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      if (bus.MST) mst_n++;
      if (!bus.STALLMD || k >= int'(MAX_LAT) + 10) break;
    end
    chk("stall_release", 64'(bus.STALLMD), 64'd0);
    chk("latency_bound", 64'(k >= 5 && k <= int'(MAX_LAT) + 3), 64'd1);
    chk("hi", 64'(bus.HI), 64'(eh));
    chk("lo", 64'(bus.LO), 64'(el));
    chk("err", 64'(bus.ERR), 64'(eerr));
    chk("mst_pulses", 64'(mst_n), 64'd1);
    chk("srca_held", 64'(bus.SRCA), 64'(a));
    bus.MFLOE = 1'b0;
  endtask

  idle_vec_t iv[5];
  mul_vec_t  mv[6];

  initial begin
    n_cmp = 0; n_bad = 0; hold = 1'b0;
    bus.MULTE = 0; bus.MSGNE = 0; bus.RSE = '0; bus.RTE = '0;
    bus.MTHIE = 0; bus.MTLOE = 0; bus.MFHIE = 0; bus.MFLOE = 0;

    iv[0] = '{1, 0, 0, 0, 32'h12345678, 32'h12345678, 32'h00000000};
    iv[1] = '{0, 1, 0, 0, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0};
    iv[2] = '{0, 0, 1, 1, 32'hFFFFFFFF, 32'h12345678, 32'h9ABCDEF0};
    iv[3] = '{1, 1, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D};
    iv[4] = '{0, 1, 0, 1, 32'h00000001, 32'hCAFEF00D, 32'h00000001};

    mv[0] = '{0, 32'd7,        32'd6,        0, 32'h00000000, 32'h0000002A};
    mv[1] = '{1, 32'hFFFFFFFD, 32'd5,        0, 32'hFFFFFFFF, 32'hFFFFFFF1};
    mv[2] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 32'h00000001};
    mv[3] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000000, 32'h00000001};
    mv[4] = '{1, 32'h80000000, 32'd2,        0, 32'hFFFFFFFF, 32'h00000000};
    mv[5] = '{0, 32'h00010001, 32'h00010001, 0, 32'h00000001, 32'h00020001};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_hi",   64'(bus.HI),   64'd0);
    chk("rst_lo",   64'(bus.LO),   64'd0);
    chk("rst_srca", 64'(bus.SRCA), 64'd0);
    chk("rst_srcb", 64'(bus.SRCB), 64'd0);
    chk("rst_mst",  64'(bus.MST),  64'd0);
    chk("rst_msgn", 64'(bus.MSGN), 64'd0);
    chk("rst_err",  64'(bus.ERR),  64'd0);

    // IDLE moves: HI/LO update on the next edge and nothing stalls
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.MTHIE = iv[i].mthi; bus.MTLOE = iv[i].mtlo;
      bus.MFHIE = iv[i].mfhi; bus.MFLOE = iv[i].mflo; bus.RSE = iv[i].rse;
      #1 chk("idle_stall", 64'(bus.STALLMD), 64'd0);
      @(negedge clk);
      chk("idle_hi", 64'(bus.HI), 64'(iv[i].exp_hi));
      chk("idle_lo", 64'(bus.LO), 64'(iv[i].exp_lo));
      bus.MTHIE = 0; bus.MTLOE = 0; bus.MFHIE = 0; bus.MFLOE = 0;
    end

    for (int i = 0; i < 6; i++)
      do_mult(mv[i].sgn, mv[i].a, mv[i].b, mv[i].mthi, mv[i].exp_hi, mv[i].exp_lo, 1'b0);

    // Reset while the multiply is waiting on PRODV
    @(negedge clk);
    bus.MULTE = 1'b1; bus.MSGNE = 1'b0; bus.RSE = 32'h10; bus.RTE = 32'h10;
    @(negedge clk);
    bus.MULTE = 1'b0; bus.MFLOE = 1'b1;
    repeat (2) @(negedge clk);
    chk("wait_stall", 64'(bus.STALLMD), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_hi",    64'(bus.HI),      64'd0);
    chk("abort_lo",    64'(bus.LO),      64'd0);
    chk("abort_mst",   64'(bus.MST),     64'd0);
    chk("abort_stall", 64'(bus.STALLMD), 64'd0);
    repeat (8) @(negedge clk);
    chk("abort_no_write", 64'({bus.HI, bus.LO}), 64'd0);
    bus.MFLOE = 1'b0;
    do_mult(1'b0, 32'd3, 32'd3, 1'b0, 32'd0, 32'd9, 1'b0);

    // multserial never completes: timeout sets sticky ERR, HI/LO untouched
    hold = 1'b1;
    do_mult(1'b0, 32'd2, 32'd2, 1'b0, 32'd0, 32'd9, 1'b1);
    hold = 1'b0;
    repeat (M_LAT + 2) @(negedge clk);
    chk("err_sticky", 64'(bus.ERR), 64'd1);
    do_mult(1'b0, 32'd3, 32'd5, 1'b0, 32'd0, 32'h0000000F, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("err_cleared", 64'(bus.ERR), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
